// File: rtl/rr_chipsel_arbiter_if.sv
// Requester/decoder-side signal bundle of the round-robin chip-select arbiter.
// All request and decoder lines are active low except a, b, busy and timeout.
interface rr_chipsel_arbiter_if;
  logic [3:0] req_l;
  logic       g_l;
  logic       a;
  logic       b;
  logic [3:0] gnt_l;
  logic       busy;
  logic       timeout;

  modport master (
    output req_l,
    input  g_l, a, b, gnt_l, busy, timeout
  );

  modport slave (
    input  req_l,
    output g_l, a, b, gnt_l, busy, timeout
  );
endinterface

// File: rtl/rr_chipsel_arbiter.sv
// Four-way round-robin arbiter that drives a shared 74x139-style 2-to-4 decoder,
// with a guard cycle on both sides of each grant and a MAX_HOLD grant limit.
module rr_chipsel_arbiter #(
  parameter int unsigned MAX_HOLD = 32'd8
) (
  input  logic                 clk,
  input  logic                 reset,
  rr_chipsel_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GUARD   = 2'd1,
    GRANT   = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 32'd1);

  state_t     state_r, state_s;
  logic [1:0] sel_r, sel_s;
  logic [1:0] last_r, last_s;
  logic [7:0] cnt_r, cnt_s;
  logic       g_l_r, g_l_s;
  logic [3:0] gnt_l_r, gnt_l_s;
  logic       busy_r, busy_s;
  logic       timeout_r, timeout_s;

  // First requester found scanning last+1, last+2, last+3, last.
  function automatic logic [1:0] pick(input logic [3:0] req_l_v, input logic [1:0] last_v);
    logic [1:0] idx;
    pick = last_v;
    for (int k = 4; k >= 1; k--) begin
      idx = last_v + 2'(k);
      if (!req_l_v[idx]) begin
        pick = idx;
      end
    end
  endfunction

  // Next-state logic; outputs are derived from the next state so they can be registered.
  always_comb begin
    state_s   = state_r;
    sel_s     = sel_r;
    last_s    = last_r;
    cnt_s     = cnt_r;
    timeout_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (!(&bus.req_l)) begin
          sel_s   = pick(bus.req_l, last_r);
          state_s = GUARD;
        end else begin
          state_s = IDLE;
        end
      end
      GUARD: begin
        if (!bus.req_l[sel_r]) begin
          state_s = GRANT;
          cnt_s   = 8'd0;
        end else begin
          state_s = IDLE;
        end
      end
      GRANT: begin
        if (bus.req_l[sel_r]) begin
          state_s = RELEASE;
        end else if (cnt_r == HOLD_LAST) begin
          state_s   = RELEASE;
          timeout_s = 1'b1;
        end else begin
          cnt_s = cnt_r + 8'd1;
        end
      end
      RELEASE: begin
        last_s  = sel_r;
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    g_l_s   = (state_s != GRANT);
    gnt_l_s = (state_s == GRANT) ? ~(4'b0001 << sel_s) : 4'b1111;
    busy_s  = (state_s != IDLE);
  end

  // State, pointer, counter and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      sel_r     <= 2'd0;
      last_r    <= 2'd3;
      cnt_r     <= 8'd0;
      g_l_r     <= 1'b1;
      gnt_l_r   <= 4'b1111;
      busy_r    <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      sel_r     <= sel_s;
      last_r    <= last_s;
      cnt_r     <= cnt_s;
      g_l_r     <= g_l_s;
      gnt_l_r   <= gnt_l_s;
      busy_r    <= busy_s;
      timeout_r <= timeout_s;
    end
  end

  assign bus.g_l     = g_l_r;
  assign bus.a       = sel_r[0];
  assign bus.b       = sel_r[1];
  assign bus.gnt_l   = gnt_l_r;
  assign bus.busy    = busy_r;
  assign bus.timeout = timeout_r;

endmodule

// File: tb/tb_rr_chipsel_arbiter.sv
// Table-driven bench for rr_chipsel_arbiter: one instance with MAX_HOLD=8 and
// one with MAX_HOLD=1, sharing clock and reset.
module tb_rr_chipsel_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  rr_chipsel_arbiter_if if8();
  rr_chipsel_arbiter_if if1();

  rr_chipsel_arbiter #(.MAX_HOLD(32'd8)) dut8 (.clk(clk), .reset(rst), .bus(if8.slave));
  rr_chipsel_arbiter #(.MAX_HOLD(32'd1)) dut1 (.clk(clk), .reset(rst), .bus(if1.slave));

  typedef struct {
    logic       rst;
    logic       which;
    logic [3:0] req;
    logic       g_l;
    logic [3:0] gnt;
    logic [1:0] ba;
    logic       busy;
    logic       to;
  } vec_t;

  vec_t vecs[$];
  int   applied = 0;
  int   bad = 0;

  task automatic add(input logic r, input logic w, input logic [3:0] q, input logic g,
                     input logic [3:0] n, input logic [1:0] ba, input logic bz, input logic to);
    vec_t v;
    v.rst = r; v.which = w; v.req = q; v.g_l = g;
    v.gnt = n; v.ba = ba; v.busy = bz; v.to = to;
    vecs.push_back(v);
  endtask

  // Drive one cycle of inputs, then compare {g_l, gnt_l, b, a, busy, timeout} after the edge.
  task automatic apply(input vec_t v, input string name);
    logic [8:0] got;
    logic [8:0] want;
    rst = v.rst;
    if8.req_l = v.which ? 4'b1111 : v.req;
    if1.req_l = v.which ? v.req : 4'b1111;
    @(posedge clk);
    #1;
    if (v.which) got = {if1.g_l, if1.gnt_l, if1.b, if1.a, if1.busy, if1.timeout};
    else         got = {if8.g_l, if8.gnt_l, if8.b, if8.a, if8.busy, if8.timeout};
    want = {v.g_l, v.gnt, v.ba, v.busy, v.to};
    applied++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: g_l/gnt_l/ba/busy/timeout got %b required %b", name, got, want);
    end
  endtask

  initial begin
    logic [1:0] ba;
    logic [3:0] gn;
    vec_t       h;

    if8.req_l = 4'b1111;
    if1.req_l = 4'b1111;

    // Reset, then idle with no requests.
    add(1'b1, 1'b0, 4'b1111, 1'b1, 4'b1111, 2'd0, 1'b0, 1'b0);
    add(1'b1, 1'b0, 4'b1111, 1'b1, 4'b1111, 2'd0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) add(1'b0, 1'b0, 4'b1111, 1'b1, 4'b1111, 2'd0, 1'b0, 1'b0);

    // Requester 1 for three cycles, then 0 and 2 together go to 2.
    add(1'b0, 1'b0, 4'b1101, 1'b1, 4'b1111, 2'd1, 1'b1, 1'b0);
    add(1'b0, 1'b0, 4'b1101, 1'b0, 4'b1101, 2'd1, 1'b1, 1'b0);
    add(1'b0, 1'b0, 4'b1101, 1'b0, 4'b1101, 2'd1, 1'b1, 1'b0);
    add(1'b0, 1'b0, 4'b1111, 1'b1, 4'b1111, 2'd1, 1'b1, 1'b0);
    add(1'b0, 1'b0, 4'b1111, 1'b1, 4'b1111, 2'd1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 4'b1010, 1'b1, 4'b1111, 2'd2, 1'b1, 1'b0);
    add(1'b0, 1'b0, 4'b1010, 1'b0, 4'b1011, 2'd2, 1'b1, 1'b0);
    add(1'b0, 1'b0, 4'b1111, 1'b1, 4'b1111, 2'd2, 1'b1, 1'b0);
    add(1'b0, 1'b0, 4'b1111, 1'b1, 4'b1111, 2'd2, 1'b0, 1'b0);

    // Requester 3 withdraws in GUARD; LAST stays 2 so 3 beats 0 next.
    add(1'b0, 1'b0, 4'b0111, 1'b1, 4'b1111, 2'd3, 1'b1, 1'b0);
    add(1'b0, 1'b0, 4'b1111, 1'b1, 4'b1111, 2'd3, 1'b0, 1'b0);
    add(1'b0, 1'b0, 4'b1111, 1'b1, 4'b1111, 2'd3, 1'b0, 1'b0);
    add(1'b0, 1'b0, 4'b0110, 1'b1, 4'b1111, 2'd3, 1'b1, 1'b0);
    add(1'b0, 1'b0, 4'b0110, 1'b0, 4'b0111, 2'd3, 1'b1, 1'b0);
    add(1'b0, 1'b0, 4'b1110, 1'b1, 4'b1111, 2'd3, 1'b1, 1'b0);
    add(1'b0, 1'b0, 4'b1111, 1'b1, 4'b1111, 2'd3, 1'b0, 1'b0);

    // Persistent 0 and 2: four forced grants of 8 cycles alternating 0,2,0,2.
    add(1'b0, 1'b0, 4'b1010, 1'b1, 4'b1111, 2'd0, 1'b1, 1'b0);
    for (int g = 0; g < 4; g++) begin
      ba = (g % 2 == 0) ? 2'd0 : 2'd2;
      gn = (g % 2 == 0) ? 4'b1110 : 4'b1011;
      for (int c = 0; c < 8; c++) add(1'b0, 1'b0, 4'b1010, 1'b0, gn, ba, 1'b1, 1'b0);
      add(1'b0, 1'b0, 4'b1010, 1'b1, 4'b1111, ba, 1'b1, 1'b1);
      if (g < 3) begin
        add(1'b0, 1'b0, 4'b1010, 1'b1, 4'b1111, ba, 1'b0, 1'b0);
        add(1'b0, 1'b0, 4'b1010, 1'b1, 4'b1111, ba ^ 2'd2, 1'b1, 1'b0);
      end
    end
    add(1'b0, 1'b0, 4'b1111, 1'b1, 4'b1111, 2'd2, 1'b0, 1'b0);

    // Reset in the 4th GRANT cycle of requester 2; afterwards 2 beats 3.
    add(1'b0, 1'b0, 4'b1011, 1'b1, 4'b1111, 2'd2, 1'b1, 1'b0);
    for (int c = 0; c < 4; c++) add(1'b0, 1'b0, 4'b1011, 1'b0, 4'b1011, 2'd2, 1'b1, 1'b0);
    add(1'b1, 1'b0, 4'b1011, 1'b1, 4'b1111, 2'd0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 4'b0011, 1'b1, 4'b1111, 2'd2, 1'b1, 1'b0);
    add(1'b0, 1'b0, 4'b0011, 1'b0, 4'b1011, 2'd2, 1'b1, 1'b0);
    add(1'b0, 1'b0, 4'b1111, 1'b1, 4'b1111, 2'd2, 1'b1, 1'b0);
    add(1'b0, 1'b0, 4'b1111, 1'b1, 4'b1111, 2'd2, 1'b0, 1'b0);

    // MAX_HOLD=1 with all four requesting: order 0,1,2,3,0, TIMEOUT after each.
    for (int k = 0; k < 5; k++) begin
      ba = 2'(k % 4);
      gn = ~(4'b0001 << ba);
      add(1'b0, 1'b1, 4'b0000, 1'b1, 4'b1111, ba, 1'b1, 1'b0);
      add(1'b0, 1'b1, 4'b0000, 1'b0, gn, ba, 1'b1, 1'b0);
      add(1'b0, 1'b1, 4'b0000, 1'b1, 4'b1111, ba, 1'b1, 1'b1);
      add(1'b0, 1'b1, 4'b0000, 1'b1, 4'b1111, ba, 1'b0, 1'b0);
    end

    foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

    // MAX_HOLD=1, request withdrawn during the single grant cycle: no TIMEOUT.
    h.rst = 1'b0; h.which = 1'b1;
    h.req = 4'b1110; h.g_l = 1'b1; h.gnt = 4'b1111; h.ba = 2'd0; h.busy = 1'b1; h.to = 1'b0;
    apply(h, "hold1_guard");
    h.req = 4'b1110; h.g_l = 1'b0; h.gnt = 4'b1110;
    apply(h, "hold1_grant");
    h.req = 4'b1111; h.g_l = 1'b1; h.gnt = 4'b1111;
    apply(h, "hold1_release_no_timeout");
    h.busy = 1'b0;
    apply(h, "hold1_idle");

    $display("== %0d vectors applied, %0d miscompares ==", applied, bad);
    $finish;
  end

endmodule
